test_detector_emulator: RTL and testbench
=========================================

# test_detector_emulator

Generates synthetic hit patterns on a 64-bit detector bus so the detector readout chain can be exercised without a real detector. It sits in place of the physical detector inputs and drives bursts of timed pulses on selectable channels. The detector reader captures those pulses, ORs them over its window and reports per-half activity. All configuration is latched at trigger, so software can rewrite registers during a burst without corrupting it.

## Interface
- DATA_WIDTH, 64, detector bus width; must be a power of two ≥ 8.
- CNTR_WIDTH, 16, width of the timing and pulse counters.

- aclk  in  1  system clock.
- aresetn  in  1  reset, asynchronous, active-low.
- cfg_mask  in  DATA_WIDTH  channel mask; defines the pulse pattern source.
- cfg_width  in  CNTR_WIDTH  pulse high time in cycles; 0 is treated as 1.
- cfg_gap  in  CNTR_WIDTH  low time between pulses in cycles; 0 is treated as 1.
- cfg_count  in  CNTR_WIDTH  number of pulses per burst; 0 means continuous until stop.
- cfg_mode  in  2  pattern mode (see Operation).
- trg  in  1  start request, level-sampled, accepted only in IDLE.
- stop  in  1  abort request, sampled every cycle.
- det_data  out  DATA_WIDTH  emulated detector bus, registered.
- busy  out  1  high while a burst is in progress.
- pulse_cntr  out  CNTR_WIDTH  number of pulses emitted in the current or last burst.

## Operation
- **Reset values:** state IDLE; det_data 0; busy 0; pulse_cntr 0; all latched config 0.
- **States:** IDLE, HIGH, LOW.
- **IDLE → HIGH:** on trg=1 and stop=0.
  - Latch cfg_mask, cfg_width, cfg_gap, cfg_count and cfg_mode.
  - Load the timer with max(width,1)−1.
  - Set pulse_cntr to 1.
  - det_data takes the first pattern.
- **HIGH:** det_data holds the pattern; the timer decrements each cycle.
  - At timer=0: go to LOW, det_data becomes 0, timer loads max(gap,1)−1.
- **LOW:** det_data is 0; the timer decrements.
  - At timer=0 with count≠0 and pulse_cntr=count: go to IDLE, busy falls.
  - At timer=0 otherwise: go to HIGH, pulse_cntr increments (wraps in continuous mode), det_data takes the next pattern.
- **Pattern modes:**
  - 0 (static): every pulse is the latched mask.
  - 1 (walk): each pulse is a single bit. The first pulse is the lowest set bit of the mask. Each next pulse is the next set bit above the previous one, wrapping from the highest set bit back to the lowest.
  - 2 (rotate): the first pulse is the mask. Each next pulse is the previous pattern rotated left by 1.
  - 3: reserved, behaves as mode 0.
- **Mask = 0:** timing runs normally; det_data stays 0; pulse_cntr still counts.
- **stop=1 in any state:** next state IDLE, det_data 0, busy 0. pulse_cntr holds its value.
- **stop and trg in the same cycle:** stop wins; no burst starts.
- **trg while busy:** ignored; no restart, no queueing.
- **Config changes mid-burst:** no effect until the next accepted trigger.
- **Reset mid-burst:** all outputs return to their reset values immediately (asynchronous).

## Timing
- trg sampled high at edge t:
  - busy=1 and det_data=pattern from t+1.
  - det_data high for max(width,1) cycles.
  - det_data low for max(gap,1) cycles.
- Pulse period is max(width,1)+max(gap,1) cycles.
- **Finite burst:** busy falls exactly count·period cycles after t+1. A new trg is accepted on that same IDLE cycle.
- **stop at edge s:** det_data=0 and busy=0 from s+1.
- **Registers:** det_data, busy and pulse_cntr are flops with no combinational path from inputs. Latency from trg to det_data is 1 cycle.
- **Walk-mode next-bit:** computed combinationally from the current pattern and the latched mask, in the same cycle the LOW→HIGH transition occurs.

## Structure
- **Shared package test_detector_pkg:**
  - state enum (IDLE, HIGH, LOW);
  - mode constants MODE_STATIC=0, MODE_WALK=1, MODE_ROTATE=2.
  - The detector reader also uses this package.
- **Sub-module test_detector_walk_sel:**
  - Inputs: mask and current one-hot bit.
  - Outputs: the next set bit above the current one, with wrap-around, and the lowest set bit when the current bit is 0.
  - Implemented as a pure combinational priority search over DATA_WIDTH bits.

## Test plan
- **Static burst:** mode 0, mask 0x0001_0000_0000_0001, width 3, gap 2, count 4, trg pulse. Expect 4 pulses of 3 cycles high and 2 low, busy high for 20 cycles, pulse_cntr=4.
- **Walk:** mode 1, mask 0x8000_0000_0000_0101, width 1, gap 1, count 4. Expect det_data 0x1, 0x100, 0x8000_0000_0000_0000, 0x1.
- **Rotate and zero handling:** mode 2, mask 0x8000_0000_0000_0001, width 0, gap 0, count 2. Expect 0x8000_0000_0000_0001 then 0x3, each lasting 1 cycle, busy high for 4 cycles.
- **Continuous and stop:** count 0, width 2, gap 2. Let 10 pulses pass, then assert stop mid-HIGH. Expect det_data=0 and busy=0 one cycle later, pulse_cntr=10. Also assert trg and stop together in IDLE: no burst starts.
- **Robustness:** re-trigger and rewrite config during a burst; both are ignored. Assert aresetn low mid-pulse: det_data, busy and pulse_cntr go to 0 asynchronously, and a trg after release starts cleanly.

Source files
------------

// File: rtl/test_detector_pkg.sv
// Shared types and mode constants for the test detector emulator and the detector reader.
package test_detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;

  // The reserved mode folds onto static so downstream logic only sees three modes.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    norm_mode = (mode == 2'd3) ? MODE_STATIC : mode;
  endfunction

endpackage

// File: rtl/test_detector_walk_sel.sv
// Walk-mode bit selector: next set mask bit strictly above the current one-hot bit,
// wrapping to the lowest set bit (also used when the current bit is zero).
module test_detector_walk_sel
  import test_detector_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] cur_bit,
  output logic [DATA_WIDTH-1:0] next_bit
);

  logic [DATA_WIDTH-1:0] low_bit_s;
  logic [DATA_WIDTH-1:0] above_bit_s;
  logic                  low_hit_s;
  logic                  above_hit_s;
  logic                  seen_cur_s;

  // Priority search: lowest set bit overall and lowest set bit above the current bit.
  always_comb begin
    low_bit_s   = {DATA_WIDTH{1'b0}};
    above_bit_s = {DATA_WIDTH{1'b0}};
    low_hit_s   = 1'b0;
    above_hit_s = 1'b0;
    seen_cur_s  = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      low_bit_s[i]   = mask[i] & ~low_hit_s;
      low_hit_s      = low_hit_s | mask[i];
      above_bit_s[i] = mask[i] & seen_cur_s & ~above_hit_s;
      above_hit_s    = above_hit_s | above_bit_s[i];
      seen_cur_s     = seen_cur_s | cur_bit[i];
    end
    next_bit = above_hit_s ? above_bit_s : low_bit_s;
  end

endmodule

// File: rtl/test_detector_emulator.sv
// Synthetic detector hit generator: bursts of timed pulses on a masked channel pattern,
// with all configuration captured when the trigger is accepted.
module test_detector_emulator
  import test_detector_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNTR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  input  logic [CNTR_WIDTH-1:0] cfg_width,
  input  logic [CNTR_WIDTH-1:0] cfg_gap,
  input  logic [CNTR_WIDTH-1:0] cfg_count,
  input  logic [1:0]            cfg_mode,
  input  logic                  trg,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] det_data,
  output logic                  busy,
  output logic [CNTR_WIDTH-1:0] pulse_cntr
);

  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [CNTR_WIDTH-1:0] CNT_ZERO  = {CNTR_WIDTH{1'b0}};
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE   = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  // A zero width or gap behaves as one cycle.
  function automatic logic [CNTR_WIDTH-1:0] load_val(input logic [CNTR_WIDTH-1:0] v);
    load_val = (v == CNT_ZERO) ? CNT_ZERO : (v - CNT_ONE);
  endfunction

  state_t                state_r;
  state_t                next_state_s;
  logic [CNTR_WIDTH-1:0] timer_r;
  logic [CNTR_WIDTH-1:0] next_timer_s;
  logic [DATA_WIDTH-1:0] pat_r;
  logic [DATA_WIDTH-1:0] next_pat_s;
  logic [DATA_WIDTH-1:0] mask_r;
  logic [DATA_WIDTH-1:0] next_mask_s;
  logic [CNTR_WIDTH-1:0] width_r;
  logic [CNTR_WIDTH-1:0] next_width_s;
  logic [CNTR_WIDTH-1:0] gap_r;
  logic [CNTR_WIDTH-1:0] next_gap_s;
  logic [CNTR_WIDTH-1:0] count_r;
  logic [CNTR_WIDTH-1:0] next_count_s;
  logic [1:0]            mode_r;
  logic [1:0]            next_mode_s;
  logic [DATA_WIDTH-1:0] next_det_s;
  logic                  next_busy_s;
  logic [CNTR_WIDTH-1:0] next_pcnt_s;

  logic [DATA_WIDTH-1:0] walk_mask_s;
  logic [DATA_WIDTH-1:0] walk_cur_s;
  logic [DATA_WIDTH-1:0] walk_next_s;
  logic [DATA_WIDTH-1:0] first_pat_s;
  logic [DATA_WIDTH-1:0] follow_pat_s;

  // In IDLE the selector looks at the incoming mask with no current bit, yielding the first walk bit.
  assign walk_mask_s = (state_r == IDLE) ? cfg_mask : mask_r;
  assign walk_cur_s  = (state_r == IDLE) ? DATA_ZERO : pat_r;

  test_detector_walk_sel #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_walk_sel (
    .mask     (walk_mask_s),
    .cur_bit  (walk_cur_s),
    .next_bit (walk_next_s)
  );

  // Pattern for the pulse started by a trigger and for each following pulse.
  always_comb begin
    first_pat_s  = cfg_mask;
    follow_pat_s = mask_r;
    case (norm_mode(cfg_mode))
      MODE_WALK: first_pat_s = walk_next_s;
      default:   first_pat_s = cfg_mask;
    endcase
    case (mode_r)
      MODE_WALK:   follow_pat_s = walk_next_s;
      MODE_ROTATE: follow_pat_s = {pat_r[DATA_WIDTH-2:0], pat_r[DATA_WIDTH-1]};
      default:     follow_pat_s = mask_r;
    endcase
  end

  // Next-state and next-output logic; stop overrides everything and leaves pulse_cntr intact.
  always_comb begin
    next_state_s = state_r;
    next_timer_s = timer_r;
    next_pat_s   = pat_r;
    next_mask_s  = mask_r;
    next_width_s = width_r;
    next_gap_s   = gap_r;
    next_count_s = count_r;
    next_mode_s  = mode_r;
    next_det_s   = det_data;
    next_busy_s  = busy;
    next_pcnt_s  = pulse_cntr;
    if (stop) begin
      next_state_s = IDLE;
      next_det_s   = DATA_ZERO;
      next_busy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (trg) begin
            next_state_s = HIGH;
            next_mask_s  = cfg_mask;
            next_width_s = cfg_width;
            next_gap_s   = cfg_gap;
            next_count_s = cfg_count;
            next_mode_s  = norm_mode(cfg_mode);
            next_timer_s = load_val(cfg_width);
            next_pcnt_s  = CNT_ONE;
            next_pat_s   = first_pat_s;
            next_det_s   = first_pat_s;
            next_busy_s  = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end
        HIGH: begin
          if (timer_r == CNT_ZERO) begin
            next_state_s = LOW;
            next_det_s   = DATA_ZERO;
            next_timer_s = load_val(gap_r);
          end else begin
            next_timer_s = timer_r - CNT_ONE;
          end
        end
        LOW: begin
          if (timer_r == CNT_ZERO) begin
            if ((count_r != CNT_ZERO) && (pulse_cntr == count_r)) begin
              next_state_s = IDLE;
              next_busy_s  = 1'b0;
            end else begin
              next_state_s = HIGH;
              next_pcnt_s  = pulse_cntr + CNT_ONE;
              next_pat_s   = follow_pat_s;
              next_det_s   = follow_pat_s;
              next_timer_s = load_val(width_r);
            end
          end else begin
            next_timer_s = timer_r - CNT_ONE;
          end
        end
        default: begin
          next_state_s = IDLE;
          next_det_s   = DATA_ZERO;
          next_busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= IDLE;
      timer_r    <= CNT_ZERO;
      pat_r      <= DATA_ZERO;
      mask_r     <= DATA_ZERO;
      width_r    <= CNT_ZERO;
      gap_r      <= CNT_ZERO;
      count_r    <= CNT_ZERO;
      mode_r     <= MODE_STATIC;
      det_data   <= DATA_ZERO;
      busy       <= 1'b0;
      pulse_cntr <= CNT_ZERO;
    end else begin
      state_r    <= next_state_s;
      timer_r    <= next_timer_s;
      pat_r      <= next_pat_s;
      mask_r     <= next_mask_s;
      width_r    <= next_width_s;
      gap_r      <= next_gap_s;
      count_r    <= next_count_s;
      mode_r     <= next_mode_s;
      det_data   <= next_det_s;
      busy       <= next_busy_s;
      pulse_cntr <= next_pcnt_s;
    end
  end

endmodule

// File: tb/tb_test_detector_emulator.sv
// Directed bench for test_detector_emulator: static, walk, rotate, continuous/stop and robustness bursts.
module tb_test_detector_emulator;

  logic        aclk;
  logic        aresetn;
  logic [63:0] cfg_mask;
  logic [15:0] cfg_width;
  logic [15:0] cfg_gap;
  logic [15:0] cfg_count;
  logic [1:0]  cfg_mode;
  logic        trg;
  logic        stop;
  logic [63:0] det_data;
  logic        busy;
  logic [15:0] pulse_cntr;

  int checks = 0;
  int errors = 0;

  test_detector_emulator #(
    .DATA_WIDTH (64),
    .CNTR_WIDTH (16)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_mask   (cfg_mask),
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_count  (cfg_count),
    .cfg_mode   (cfg_mode),
    .trg        (trg),
    .stop       (stop),
    .det_data   (det_data),
    .busy       (busy),
    .pulse_cntr (pulse_cntr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [63:0] e_det, input logic e_busy,
                          input logic [15:0] e_pcnt);
    chk({tag, "_det"}, det_data, e_det);
    chk({tag, "_busy"}, {63'h0, busy}, {63'h0, e_busy});
    chk({tag, "_pcnt"}, {48'h0, pulse_cntr}, {48'h0, e_pcnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m;
    logic [63:0] wexp [4];

    aresetn   = 1'b0;
    cfg_mask  = 64'h0;
    cfg_width = 16'd0;
    cfg_gap   = 16'd0;
    cfg_count = 16'd0;
    cfg_mode  = 2'd0;
    trg       = 1'b0;
    stop      = 1'b0;

    // Reset state
    @(negedge aclk);
    chk_outs("reset", 64'h0, 1'b0, 16'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk_outs("idle", 64'h0, 1'b0, 16'd0);

    // Static burst: 4 pulses, 3 high + 2 low
    m = 64'h0001_0000_0000_0001;
    cfg_mask = m; cfg_width = 16'd3; cfg_gap = 16'd2; cfg_count = 16'd4; cfg_mode = 2'd0;
    trg = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge aclk);
      trg = 1'b0;
      chk_outs("static",
               (c <= 20 && ((c - 1) % 5) < 3) ? m : 64'h0,
               c <= 20,
               (c <= 20) ? 16'((c - 1) / 5 + 1) : 16'd4);
    end

    // Walk: single bits climbing through the mask with wrap
    m = 64'h8000_0000_0000_0101;
    wexp[0] = 64'h1; wexp[1] = 64'h100; wexp[2] = 64'h8000_0000_0000_0000; wexp[3] = 64'h1;
    cfg_mask = m; cfg_width = 16'd1; cfg_gap = 16'd1; cfg_count = 16'd4; cfg_mode = 2'd1;
    trg = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge aclk);
      trg = 1'b0;
      chk_outs("walk",
               (c <= 8 && (c % 2) == 1) ? wexp[(c - 1) / 2] : 64'h0,
               c <= 8,
               (c <= 8) ? 16'((c - 1) / 2 + 1) : 16'd4);
    end

    // Rotate with zero width and gap
    m = 64'h8000_0000_0000_0001;
    cfg_mask = m; cfg_width = 16'd0; cfg_gap = 16'd0; cfg_count = 16'd2; cfg_mode = 2'd2;
    trg = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge aclk);
      trg = 1'b0;
      chk_outs("rotate",
               (c == 1) ? m : ((c == 3) ? 64'h3 : 64'h0),
               c <= 4,
               (c <= 2) ? 16'd1 : 16'd2);
    end

    // Continuous burst, stop in the high phase of pulse 10
    m = 64'h0000_0000_0000_00F0;
    cfg_mask = m; cfg_width = 16'd2; cfg_gap = 16'd2; cfg_count = 16'd0; cfg_mode = 2'd0;
    trg = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge aclk);
      trg = 1'b0;
      chk_outs("cont", (((c - 1) % 4) < 2) ? m : 64'h0, 1'b1, 16'((c - 1) / 4 + 1));
    end
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
    chk_outs("stop", 64'h0, 1'b0, 16'd10);
    @(negedge aclk);
    chk_outs("stop_idle", 64'h0, 1'b0, 16'd10);

    // Trigger and stop together in IDLE: nothing starts
    trg = 1'b1; stop = 1'b1;
    @(negedge aclk);
    trg = 1'b0; stop = 1'b0;
    chk_outs("trg_stop", 64'h0, 1'b0, 16'd10);
    @(negedge aclk);
    chk_outs("trg_stop2", 64'h0, 1'b0, 16'd10);

    // Re-trigger and config rewrite mid-burst are ignored
    m = 64'h0000_0000_0000_00FF;
    cfg_mask = m; cfg_width = 16'd2; cfg_gap = 16'd1; cfg_count = 16'd3; cfg_mode = 2'd0;
    trg = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge aclk);
      if (c == 1) trg = 1'b0;
      chk_outs("robust",
               (c <= 9 && ((c - 1) % 3) < 2) ? m : 64'h0,
               c <= 9,
               (c <= 9) ? 16'((c - 1) / 3 + 1) : 16'd3);
      if (c == 2) begin
        cfg_mask = 64'h0000_0000_FF00_0000; cfg_width = 16'd5; cfg_gap = 16'd7;
        cfg_count = 16'd1; cfg_mode = 2'd2; trg = 1'b1;
      end
      if (c == 7) trg = 1'b0;
    end

    // New trigger accepted on the first IDLE cycle after a burst
    m = 64'h0000_0000_0000_1234;
    cfg_mask = m; cfg_width = 16'd4; cfg_gap = 16'd4; cfg_count = 16'd0; cfg_mode = 2'd0;
    trg = 1'b1;
    @(negedge aclk);
    trg = 1'b0;
    chk_outs("retrig", m, 1'b1, 16'd1);
    @(negedge aclk);
    chk_outs("retrig2", m, 1'b1, 16'd1);

    // Asynchronous reset in the middle of a pulse
    #2;
    aresetn = 1'b0;
    #1;
    chk_outs("async_rst", 64'h0, 1'b0, 16'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    chk_outs("rst_hold", 64'h0, 1'b0, 16'd0);

    // Clean start after reset release
    cfg_width = 16'd1; cfg_gap = 16'd1; cfg_count = 16'd1;
    trg = 1'b1;
    @(negedge aclk);
    trg = 1'b0;
    chk_outs("post_rst1", m, 1'b1, 16'd1);
    @(negedge aclk);
    chk_outs("post_rst2", 64'h0, 1'b1, 16'd1);
    @(negedge aclk);
    chk_outs("post_rst3", 64'h0, 1'b0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
